// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer: 8-step frame sequencer turning DIV pulses into length/sweep/envelope clock enables
module apu_frame_sequencer #(
  parameter logic [7:0] LENGTH_MASK = 8'b0101_0101,
  parameter logic [7:0] SWEEP_MASK  = 8'b0100_0100,
  parameter logic [7:0] ENV_MASK    = 8'b1000_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       apu_en,
  input  logic       div_tick,
  output logic [2:0] step,
  output logic       length_tick,
  output logic       sweep_tick,
  output logic       env_tick,
  output logic       length_skip_next
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      step        <= '0;
      length_tick <= 1'b0;
      sweep_tick  <= 1'b0;
      env_tick    <= 1'b0;
    end else if (!apu_en) begin
      step        <= '0;
      length_tick <= 1'b0;
      sweep_tick  <= 1'b0;
      env_tick    <= 1'b0;
    end else begin
      length_tick <= div_tick & LENGTH_MASK[step];
      sweep_tick  <= div_tick & SWEEP_MASK[step];
      env_tick    <= div_tick & ENV_MASK[step];
      if (div_tick) step <= step + 3'd1;
    end
  assign length_skip_next = !LENGTH_MASK[step];
endmodule

// File: tb/tb_apu_frame_sequencer.sv
// tb_apu_frame_sequencer: vector table, hand sequences and random stimulus against a pulse-count model
module tb_apu_frame_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, apu_en = 1'b0, div_tick = 1'b0;
  logic [2:0] step;
  logic length_tick, sweep_tick, env_tick, length_skip_next;
  int total = 0, bad = 0;
  int m_step = 0;
  bit m_l, m_s, m_e;

  typedef struct {
    bit en;
    bit dt;
    int st;
    bit l;
    bit s;
    bit e;
  } vec_t;
  vec_t vt[$];

  apu_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .apu_en(apu_en), .div_tick(div_tick), .step(step),
    .length_tick(length_tick), .sweep_tick(sweep_tick), .env_tick(env_tick),
    .length_skip_next(length_skip_next)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", n, got, exp, $time);
    end
  endtask

  // Model: steps counted as accepted pulses mod 8; length on even steps, sweep on steps 2 and 6, envelope on step 7
  task automatic drive(input bit en, input bit dt);
    apu_en = en;
    div_tick = dt;
    @(posedge clk);
    #1;
    if (!en) begin
      m_step = 0; m_l = 0; m_s = 0; m_e = 0;
    end else if (dt) begin
      m_l = (m_step % 2) == 0;
      m_s = (m_step % 4) == 2;
      m_e = m_step == 7;
      m_step = (m_step + 1) % 8;
    end else begin
      m_l = 0; m_s = 0; m_e = 0;
    end
  endtask

  task automatic chk_model(input string n);
    chk({n, ".step"}, int'(step), m_step);
    chk({n, ".length"}, int'(length_tick), int'(m_l));
    chk({n, ".sweep"}, int'(sweep_tick), int'(m_s));
    chk({n, ".env"}, int'(env_tick), int'(m_e));
    chk({n, ".skip"}, int'(length_skip_next), m_step % 2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apu_en = 1'b0;
    div_tick = 1'b0;
    m_step = 0; m_l = 0; m_s = 0; m_e = 0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("reset.step", int'(step), 0);
    chk("reset.ticks", int'({length_tick, sweep_tick, env_tick}), 0);
    chk("reset.skip", int'(length_skip_next), 0);
    do_reset();

    // Spaced pulses across one full frame plus the wrap pulse
    for (int p = 0; p < 9; p++) begin
      drive(1, 1);
      chk_model("spaced.pulse");
      for (int c = 0; c < 9; c++) begin
        drive(1, 0);
        chk_model("spaced.idle");
      end
    end
    chk("wrap.step", int'(step), 1);

    // Table: disable mid-frame, coincident enable edges, back-to-back pulses
    do_reset();
    vt = '{
      '{1,1,1,1,0,0}, '{1,0,1,0,0,0}, '{1,1,2,0,0,0}, '{1,1,3,1,1,0},
      '{1,1,4,0,0,0}, '{1,1,5,1,0,0}, '{0,1,0,0,0,0}, '{0,1,0,0,0,0},
      '{0,1,0,0,0,0}, '{1,1,1,1,0,0}, '{1,1,2,0,0,0}, '{1,1,3,1,1,0},
      '{1,1,4,0,0,0}, '{1,1,5,1,0,0}, '{1,1,6,0,0,0}, '{1,1,7,1,1,0},
      '{1,1,0,0,0,1}, '{1,1,1,1,0,0}, '{1,0,1,0,0,0}, '{1,1,2,0,0,0},
      '{1,1,3,1,1,0}, '{1,1,4,0,0,0}, '{1,1,5,1,0,0}, '{1,1,6,0,0,0},
      '{1,1,7,1,1,0}, '{0,1,0,0,0,0}, '{0,0,0,0,0,0}
    };
    foreach (vt[i]) begin
      drive(vt[i].en, vt[i].dt);
      chk($sformatf("vec%0d.step", i), int'(step), vt[i].st);
      chk($sformatf("vec%0d.ticks", i), int'({length_tick, sweep_tick, env_tick}),
          int'({vt[i].l, vt[i].s, vt[i].e}));
      chk($sformatf("vec%0d.skip", i), int'(length_skip_next), vt[i].st % 2);
    end

    // Async reset while env_tick is high
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, 1);
    chk("async.pre_env", int'(env_tick), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async.env", int'(env_tick), 0);
    chk("async.step", int'(step), 0);
    for (int i = 0; i < 3; i++) begin
      apu_en = 1'b1;
      div_tick = 1'b1;
      @(posedge clk);
      #1;
      chk("async.hold", int'({step, length_tick, sweep_tick, env_tick}), 0);
    end
    do_reset();

    // Random traffic with enable mostly high
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 8) != 0, $urandom % 2);
      chk_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apu_frame_sequencer.md
Name: apu_frame_sequencer

Overview:
- Consumes the single-cycle pulse from the DIV-bit edge detector, nominally 512 Hz.
- Steps an 8-phase frame sequencer and emits single-cycle clock-enable ticks to the channel units: length at 256 Hz, sweep at 128 Hz, envelope at 64 Hz.
- Sits between the DIV edge detector and channels 1–4.
- Gated by the APU master enable (NR52 bit 7).

Parameters:
- LENGTH_MASK, 8'b0101_0101: bit n set means step n issues length_tick.
- SWEEP_MASK, 8'b0100_0100: bit n set means step n issues sweep_tick.
- ENV_MASK, 8'b1000_0000: bit n set means step n issues env_tick.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- apu_en  input  1  APU master enable (NR52[7]), synchronous to clk.
- div_tick  input  1  single-cycle pulse from DIV edge detector; one pulse = one sequencer step.
- step  output  3  index of the next step to execute (registered).
- length_tick  output  1  single-cycle pulse; clock length counters.
- sweep_tick  output  1  single-cycle pulse; clock channel 1 sweep.
- env_tick  output  1  single-cycle pulse; clock volume envelopes.
- length_skip_next  output  1  high when the next step does not clock length; channels use it for the length-enable quirk.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rst_n low): takes effect immediately, independent of clk.
  - step=0; length_tick, sweep_tick, env_tick all 0.
  - length_skip_next = !LENGTH_MASK[0], which is 0 with defaults.
- Internal state: 3-bit step register plus the three registered tick flops.
- States: DISABLED (apu_en=0) and RUNNING (apu_en=1), tracked implicitly by apu_en; no separate FSM register required.
- DISABLED, every cycle:
  - step<=0; all ticks <=0.
  - div_tick is ignored and not queued.
- RUNNING, cycle with div_tick=1:
  - length_tick<=LENGTH_MASK[step], sweep_tick<=SWEEP_MASK[step], env_tick<=ENV_MASK[step].
  - step<=step+1 mod 8; 7 wraps to 0.
- RUNNING, cycle with div_tick=0: all ticks <=0; step holds.
- Latency: a tick is visible exactly one clk after the cycle div_tick was sampled high. Each tick is high for exactly one cycle per accepted div_tick.
- Back-to-back div_tick in consecutive cycles: each pulse is accepted and advances one step. Ticks may therefore be high in consecutive cycles. No pulse is merged or dropped.
- Enable edges:
  - apu_en rising in the same cycle as div_tick: the pulse is accepted as step 0. With defaults this gives length_tick=1 next cycle; step becomes 1.
  - apu_en falling in the same cycle as div_tick: the pulse is discarded; step<=0; no tick is issued.
- Ticks already high when apu_en falls complete their single cycle. They are not extended.
- length_skip_next = !LENGTH_MASK[step]; combinational from the step register only.
- No other combinational path exists from inputs to outputs.
- Default step pattern, steps 0..7:
  - L, –, L+S, –, L, –, L+S, E (L = length, S = sweep, E = envelope).
- Out-of-sequence tick combinations are impossible by construction. The masks are applied only to the registered step value.

Test Plan:
- Reset release, apu_en=1, then 8 div_tick pulses spaced 10 cycles apart:
  - length_tick on pulses 1,3,5,7; sweep_tick on 3,7; env_tick on 8. Each tick asserts exactly 1 cycle after its pulse.
  - step sequence 1,2,…,7,0.
- Wrap and skip flag: 9th pulse after the above gives length_tick=1 and step=1. length_skip_next is 0 at step 0 and 1 at step 1.
- Disable mid-sequence:
  - After 5 pulses (step=5), drop apu_en for 3 cycles while pulsing div_tick. Expect no ticks and step=0.
  - Re-enable, then pulse: expect length_tick=1, step=1.
- Back-to-back: div_tick high for 3 consecutive cycles from step=6. Expect:
  - cycle+1: length_tick and sweep_tick;
  - cycle+2: env_tick;
  - cycle+3: length_tick.
  - Final step=1.
- Coincident edges:
  - apu_en rise and div_tick in the same cycle → length_tick next cycle.
  - apu_en fall and div_tick in the same cycle at step=7 → no env_tick; step=0.
- Async reset: assert rst_n low mid-cycle while env_tick=1. env_tick and step read 0 before the next clk edge, and stay 0 until release.
